// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake and feeds IF/ID.
// Optional performance counters are enabled with `define IFU_PERF_COUNTERS_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_plus_4_out,
    output logic        valid_out
`ifdef IFU_PERF_COUNTERS_EN
    ,
    output logic [31:0] fetch_count_out,
    output logic [31:0] stall_count_out
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DROP} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] req_addr_reg, req_addr_next;
    logic        out_valid_reg, out_valid_next;
    logic [31:0] out_instr_reg, out_instr_next;
    logic [31:0] out_pc4_reg, out_pc4_next;
    logic        skid_valid_reg, skid_valid_next;
    logic [31:0] skid_instr_reg, skid_instr_next;
    logic [31:0] skid_pc4_reg, skid_pc4_next;

    logic ack_fire;
    logic consume;

    // A full skid suppresses new requests, so an accepted ack always has somewhere to land.
    assign imem_req  = (state_reg == DROP) || ((state_reg == RUN) && !skid_valid_reg);
    assign imem_addr = (state_reg == DROP) ? req_addr_reg : pc_reg;
    assign ack_fire  = imem_ack && imem_req;
    assign consume   = out_valid_reg && !stall;

    assign valid_out       = out_valid_reg;
    assign instruction_out = out_valid_reg ? out_instr_reg : 32'h0;
    assign pc_plus_4_out   = out_pc4_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            req_addr_reg   <= RESET_PC;
            out_valid_reg  <= 1'b0;
            out_instr_reg  <= 32'h0;
            out_pc4_reg    <= 32'h0;
            skid_valid_reg <= 1'b0;
            skid_instr_reg <= 32'h0;
            skid_pc4_reg   <= 32'h0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            req_addr_reg   <= req_addr_next;
            out_valid_reg  <= out_valid_next;
            out_instr_reg  <= out_instr_next;
            out_pc4_reg    <= out_pc4_next;
            skid_valid_reg <= skid_valid_next;
            skid_instr_reg <= skid_instr_next;
            skid_pc4_reg   <= skid_pc4_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        req_addr_next   = req_addr_reg;
        out_valid_next  = out_valid_reg;
        out_instr_next  = out_instr_reg;
        out_pc4_next    = out_pc4_reg;
        skid_valid_next = skid_valid_reg;
        skid_instr_next = skid_instr_reg;
        skid_pc4_next   = skid_pc4_reg;

        if (redirect_valid) begin
            pc_next         = redirect_pc & ~32'h3;
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
            // An unanswered request must be held until its ack, then thrown away.
            if ((state_reg == RUN) && imem_req && !imem_ack) begin
                req_addr_next = imem_addr;
                state_next    = DROP;
            end else if ((state_reg == DROP) && ack_fire) begin
                state_next = RUN;
            end else if (state_reg == IDLE) begin
                state_next = RUN;
            end
        end else begin
            case (state_reg)
                IDLE: state_next = RUN;
                DROP: begin
                    if (ack_fire) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    if (consume) begin
                        if (skid_valid_reg) begin
                            out_instr_next  = skid_instr_reg;
                            out_pc4_next    = skid_pc4_reg;
                            skid_valid_next = 1'b0;
                        end else begin
                            out_valid_next = 1'b0;
                        end
                    end
                    if (ack_fire) begin
                        pc_next = pc_reg + 32'd4;
                        if (!out_valid_reg || consume) begin
                            out_valid_next = 1'b1;
                            out_instr_next = imem_rdata;
                            out_pc4_next   = pc_reg + 32'd4;
                        end else begin
                            skid_valid_next = 1'b1;
                            skid_instr_next = imem_rdata;
                            skid_pc4_next   = pc_reg + 32'd4;
                        end
                    end
                end
            endcase
        end
    end

`ifdef IFU_PERF_COUNTERS_EN
    logic [31:0] fetch_count_reg;
    logic [31:0] stall_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_reg <= 32'h0;
            stall_count_reg <= 32'h0;
        end else begin
            if (!redirect_valid && (state_reg == RUN) && ack_fire) begin
                fetch_count_reg <= fetch_count_reg + 32'd1;
            end
            if (out_valid_reg && stall) begin
                stall_count_reg <= stall_count_reg + 32'd1;
            end
        end
    end

    assign fetch_count_out = fetch_count_reg;
    assign stall_count_out = stall_count_reg;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: queue-level model of the fetch stream plus directed literal checks.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] XKEY   = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_out;
    logic [31:0] pc_plus_4_out;
    logic        valid_out;
`ifdef IFU_PERF_COUNTERS_EN
    logic [31:0] fetch_count_out;
    logic [31:0] stall_count_out;
    logic [31:0] m_fetch;
    logic [31:0] m_stallc;
`endif

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instruction_out (instruction_out),
        .pc_plus_4_out   (pc_plus_4_out),
        .valid_out       (valid_out)
`ifdef IFU_PERF_COUNTERS_EN
        ,
        .fetch_count_out (fetch_count_out),
        .stall_count_out (stall_count_out)
`endif
    );

    // Memory: acks after mem_lat waiting cycles, data = address ^ XKEY.
    int mem_lat = 0;
    int mem_cnt = 0;
    assign imem_ack   = imem_req && (mem_cnt >= mem_lat);
    assign imem_rdata = imem_ack ? (imem_addr ^ XKEY) : 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (reset || !imem_req || imem_ack) mem_cnt <= 0;
        else mem_cnt <= mem_cnt + 1;
    end

    // Model: fetched-but-unconsumed instructions in arrival order (at most two).
    logic [31:0] q_instr[$];
    logic [31:0] q_pc4[$];
    logic [31:0] m_pc;
    logic [31:0] m_drop_addr;
    logic        m_drop;
    logic        m_idle;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic exp_req;
        if (reset) begin
            q_instr.delete();
            q_pc4.delete();
            m_pc   = RST_PC;
            m_drop = 1'b0;
            m_idle = 1'b1;
`ifdef IFU_PERF_COUNTERS_EN
            m_fetch  = 0;
            m_stallc = 0;
`endif
        end else begin
            exp_req = !m_idle && (m_drop || (q_instr.size() < 2));
`ifdef IFU_PERF_COUNTERS_EN
            if ((q_instr.size() > 0) && stall) m_stallc++;
`endif
            if (m_idle) begin
                m_idle = 1'b0;
            end else if (redirect_valid) begin
                q_instr.delete();
                q_pc4.delete();
                if (m_drop) begin
                    if (imem_ack) m_drop = 1'b0;
                end else if (exp_req && !imem_ack) begin
                    m_drop      = 1'b1;
                    m_drop_addr = m_pc;
                end
                m_pc = redirect_pc & ~32'h3;
            end else if (m_drop) begin
                if (imem_ack) m_drop = 1'b0;
            end else begin
                if ((q_instr.size() > 0) && !stall) begin
                    void'(q_instr.pop_front());
                    void'(q_pc4.pop_front());
                end
                if (imem_ack) begin
                    q_instr.push_back(m_pc ^ XKEY);
                    q_pc4.push_back(m_pc + 32'd4);
                    m_pc = m_pc + 32'd4;
`ifdef IFU_PERF_COUNTERS_EN
                    m_fetch++;
`endif
                end
            end
        end
    endtask

    task automatic compare();
        logic exp_valid;
        logic exp_req;
        exp_valid = q_instr.size() > 0;
        exp_req   = !m_idle && (m_drop || (q_instr.size() < 2));
        chk("model_valid_out", {31'b0, valid_out}, {31'b0, exp_valid});
        chk("model_instruction_out", instruction_out, exp_valid ? q_instr[0] : 32'h0);
        if (exp_valid) chk("model_pc_plus_4_out", pc_plus_4_out, q_pc4[0]);
        chk("model_imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) chk("model_imem_addr", imem_addr, m_drop ? m_drop_addr : m_pc);
`ifdef IFU_PERF_COUNTERS_EN
        chk("model_fetch_count", fetch_count_out, m_fetch);
        chk("model_stall_count", stall_count_out, m_stallc);
`endif
        $display("cyc t=%0t req=%b addr=%h ack=%b valid=%b instr=%h pc4=%h", $time,
                 imem_req, imem_addr, imem_ack, valid_out, instruction_out, pc_plus_4_out);
    endtask

    // Inputs are set at a falling edge; the model samples them before the rising edge.
    task automatic tick();
        #2;
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic chk_reset_values();
        chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
        chk("rst_imem_addr", imem_addr, RST_PC);
        chk("rst_valid_out", {31'b0, valid_out}, 32'h0);
        chk("rst_instruction_out", instruction_out, 32'h0);
        chk("rst_pc_plus_4_out", pc_plus_4_out, 32'h0);
`ifdef IFU_PERF_COUNTERS_EN
        chk("rst_fetch_count", fetch_count_out, 32'h0);
        chk("rst_stall_count", stall_count_out, 32'h0);
`endif
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        tick(); tick();
        chk_reset_values();

        // Zero-wait streaming from RESET_PC
        reset = 1'b0;
        tick();
        chk("first_req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0040_0000);
        tick();
        chk("first_valid", {31'b0, valid_out}, 32'h1);
        chk("first_pc4", pc_plus_4_out, 32'h0040_0004);
        chk("first_instr", instruction_out, 32'hFFBF_0000);
        tick();
        chk("second_pc4", pc_plus_4_out, 32'h0040_0008);
        chk("second_instr", instruction_out, 32'hFFBF_0004);
        repeat (4) tick();

        // Stall three cycles: skid fills, requests stop
        stall = 1'b1;
        repeat (3) tick();
        chk("stall_hold_pc4", pc_plus_4_out, 32'h0040_0018);
        chk("stall_req_off", {31'b0, imem_req}, 32'h0);
        stall = 1'b0;
        tick();
        chk("release_skid_pc4", pc_plus_4_out, 32'h0040_001C);
        chk("release_req", {31'b0, imem_req}, 32'h1);
        chk("release_addr", imem_addr, 32'h0040_001C);
        tick();
        chk("after_release_pc4", pc_plus_4_out, 32'h0040_0020);
        repeat (2) tick();

        // Redirect coinciding with an ack
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0103;
        tick();
        redirect_valid = 1'b0;
        chk("redir_valid_off", {31'b0, valid_out}, 32'h0);
        chk("redir_req", {31'b0, imem_req}, 32'h1);
        chk("redir_addr", imem_addr, 32'h0040_0100);
        tick();
        chk("redir_pc4", pc_plus_4_out, 32'h0040_0104);
        chk("redir_instr", instruction_out, 32'hFFBF_0100);
        repeat (2) tick();

        // Slow memory: redirect while a request is outstanding
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0010;
        tick();
        redirect_valid = 1'b0;
        mem_lat = 3;
        chk("slow_req_addr", imem_addr, 32'h0040_0010);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0200;
        tick();
        redirect_valid = 1'b0;
        chk("drop_hold_addr", imem_addr, 32'h0040_0010);
        chk("drop_valid_off", {31'b0, valid_out}, 32'h0);
        tick();
        chk("drop_hold_addr2", imem_addr, 32'h0040_0010);
        tick();
        chk("after_drop_addr", imem_addr, 32'h0040_0200);
        chk("after_drop_valid", {31'b0, valid_out}, 32'h0);
        repeat (4) tick();
        chk("slow_target_valid", {31'b0, valid_out}, 32'h1);
        chk("slow_target_pc4", pc_plus_4_out, 32'h0040_0204);
        chk("slow_target_instr", instruction_out, 32'hFFBF_0200);

        // Enter DROP, then reset
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0300;
        tick();
        redirect_valid = 1'b0;
        chk("drop2_addr", imem_addr, 32'h0040_0204);
        tick();
        reset = 1'b1;
        tick();
        chk_reset_values();
        reset = 1'b0; mem_lat = 0;
        tick();
        chk("refetch_addr", imem_addr, RST_PC);
        tick();
        chk("refetch_pc4", pc_plus_4_out, 32'h0040_0004);

        // 5 fetches, 4 stall cycles, 1 discarded ack
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick();
        stall = 1'b1;
        repeat (4) tick();
        stall = 1'b0;
        repeat (4) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0040;
        tick();
        redirect_valid = 1'b0;
`ifdef IFU_PERF_COUNTERS_EN
        chk("perf_fetch_5", fetch_count_out, 32'd5);
        chk("perf_stall_4", stall_count_out, 32'd4);
`endif
        chk("perf_redir_valid", {31'b0, valid_out}, 32'h0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
